// File: rtl/transmitter.sv
// UART 8N1 transmit engine: valid/ready byte intake into a one-deep holding
// register, serialized LSB first with one start (0) and one stop (1) bit.
module transmitter #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    output logic       transmitterOutput,
    output logic       busy,
    output logic       done
);

    localparam int unsigned TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        SEND,
        STOP
    } state_e;

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         hold_q, hold_d;
    logic               hold_full_q, hold_full_d;

    logic bit_end;
    logic load;
    logic accept;

    assign bit_end = (timer_q == TIMER_LAST);
    assign txReady = !hold_full_q;
    assign accept  = txValid && !hold_full_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load        = 1'b0;

        if (state_q == IDLE || bit_end) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TIMER_W'(1);
        end

        case (state_q)
            IDLE: begin
                load = hold_full_q;
            end
            START: begin
                if (bit_end) begin
                    state_d   = SEND;
                    bit_idx_d = '0;
                end
            end
            SEND: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // A pending byte follows the stop bit with no idle gap.
                if (bit_end) begin
                    if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = START;
        end

        // Accept and load are mutually exclusive: load needs hold_full_q, accept needs it clear.
        if (accept) begin
            hold_d      = txData;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    always_comb begin
        transmitterOutput = 1'b1;
        case (state_q)
            START:   transmitterOutput = 1'b0;
            SEND:    transmitterOutput = shift_q[0];
            default: transmitterOutput = 1'b1;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_transmitter.sv
// Random and directed stimulus on two transmitters (1 and 4 clks per bit),
// checked against a frame-level model and a line decoder scoreboard.
module tb_transmitter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data  [2];
    logic       tx_valid [2];
    logic       tx_ready [2];
    logic       tx_out   [2];
    logic       busy     [2];
    logic       done     [2];

    int n_total = 0;
    int n_bad   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    transmitter #(.CLKS_PER_BIT(1)) u_tx1 (
        .clk(clk), .rst(rst), .txData(tx_data[0]), .txValid(tx_valid[0]),
        .txReady(tx_ready[0]), .transmitterOutput(tx_out[0]), .busy(busy[0]), .done(done[0])
    );

    transmitter #(.CLKS_PER_BIT(4)) u_tx4 (
        .clk(clk), .rst(rst), .txData(tx_data[1]), .txValid(tx_valid[1]),
        .txReady(tx_ready[1]), .transmitterOutput(tx_out[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int cpb(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic [9:0] frame(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    // Frame-level model: a pending byte, and a frame in flight with a clock count.
    logic       m_hold_full [2];
    logic [7:0] m_hold      [2];
    logic       m_active    [2];
    logic [9:0] m_frame     [2];
    int         m_cnt       [2];
    logic [7:0] acc0 [$];
    logic [7:0] acc1 [$];

    // Line decoder state.
    logic       dec_on [2];
    int         dec_t  [2];
    logic [7:0] dec_sh [2];

    task automatic model_step(input int i);
        int  last;
        logic acc;
        last = 10 * cpb(i) - 1;
        if (rst) begin
            m_hold_full[i] = 1'b0;
            m_active[i]    = 1'b0;
            m_cnt[i]       = 0;
            dec_on[i]      = 1'b0;
            if (i == 0) acc0.delete(); else acc1.delete();
            return;
        end
        acc = tx_valid[i] && !m_hold_full[i];
        if (m_active[i] && m_cnt[i] != last) begin
            m_cnt[i]++;
        end else if (m_hold_full[i]) begin
            m_frame[i]     = frame(m_hold[i]);
            m_cnt[i]       = 0;
            m_active[i]    = 1'b1;
            m_hold_full[i] = 1'b0;
        end else begin
            m_active[i] = 1'b0;
        end
        if (acc) begin
            m_hold[i]      = tx_data[i];
            m_hold_full[i] = 1'b1;
            if (i == 0) acc0.push_back(tx_data[i]); else acc1.push_back(tx_data[i]);
        end
    endtask

    task automatic dec_step(input int i);
        int j;
        logic [7:0] want;
        logic have;
        if (!dec_on[i]) begin
            if (tx_out[i] == 1'b0) begin
                dec_on[i] = 1'b1;
                dec_t[i]  = 0;
            end
        end else begin
            dec_t[i]++;
        end
        if (dec_on[i] && (dec_t[i] % cpb(i) == 0)) begin
            j = dec_t[i] / cpb(i);
            if (j >= 1 && j <= 8) dec_sh[i][j-1] = tx_out[i];
            if (j == 9) begin
                check($sformatf("rx_stop%0d", i), tx_out[i], 1);
                have = (i == 0) ? (acc0.size() > 0) : (acc1.size() > 0);
                check($sformatf("rx_expected%0d", i), have, 1);
                if (have) begin
                    want = (i == 0) ? acc0.pop_front() : acc1.pop_front();
                    check($sformatf("rx_byte%0d", i), dec_sh[i], want);
                end
                dec_on[i] = 1'b0;
            end
        end
    endtask

    initial begin : model_proc
        for (int i = 0; i < 2; i++) begin
            m_hold_full[i] = 1'b0;
            m_hold[i]      = '0;
            m_active[i]    = 1'b0;
            m_frame[i]     = '1;
            m_cnt[i]       = 0;
            dec_on[i]      = 1'b0;
            dec_t[i]       = 0;
            dec_sh[i]      = '0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    initial begin : cycle_check
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 2; i++) begin
                    logic exp_line;
                    logic exp_done;
                    exp_line = m_active[i] ? m_frame[i][m_cnt[i] / cpb(i)] : 1'b1;
                    exp_done = m_active[i] && (m_cnt[i] == 10 * cpb(i) - 1);
                    check($sformatf("ready%0d", i), tx_ready[i], !m_hold_full[i]);
                    check($sformatf("line%0d", i), tx_out[i], exp_line);
                    check($sformatf("busy%0d", i), busy[i], m_active[i]);
                    check($sformatf("done%0d", i), done[i], exp_done);
                    dec_step(i);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [19:0] cap_line;
        logic [19:0] cap_done;
        logic [7:0]  bp [3];
        logic        rdy;
        int          n;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i]  = '0;
        end
        repeat (3) tick();
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", tx_ready[i], 1);
            check("rst_line", tx_out[i], 1);
            check("rst_busy", busy[i], 0);
            check("rst_done", done[i], 0);
        end

        // Reset held for 3 clocks while idle.
        repeat (5) tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("idle_rst_ready", tx_ready[0], 1);
        check("idle_rst_line", tx_out[0], 1);
        check("idle_rst_busy", busy[0], 0);
        check("idle_rst_done", done[0], 0);

        // Single byte 0xA5 at one clock per bit.
        tick();
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'hA5;
        tick();
        tx_valid[0] = 1'b0;
        cap_line = '0;
        cap_done = '0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            cap_line[k] = tx_out[0];
            cap_done[k] = done[0];
        end
        check("a5_line", {22'd0, cap_line[9:0]}, {22'd0, frame(8'hA5)});
        check("a5_done", {22'd0, cap_done[9:0]}, 32'h200);

        // Back-to-back 0x3C then 0xFF with txValid held.
        repeat (3) tick();
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h3C;
        tick();
        tx_data[0] = 8'hFF;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) tx_valid[0] = 1'b0;
            @(negedge clk);
            cap_line[k] = tx_out[0];
            cap_done[k] = done[0];
        end
        check("b2b_line", {12'd0, cap_line}, {12'd0, frame(8'hFF), frame(8'h3C)});
        check("b2b_done", {12'd0, cap_done}, (32'd1 << 19) | (32'd1 << 9));

        // Backpressure: three bytes offered while frames are in flight.
        repeat (3) tick();
        bp[0] = 8'h11;
        bp[1] = 8'h22;
        bp[2] = 8'h33;
        for (int b = 0; b < 3; b++) begin
            tx_valid[0] = 1'b1;
            tx_data[0]  = bp[b];
            n = 0;
            do begin
                rdy = tx_ready[0];
                tick();
                n++;
            end while (!rdy && n < 200);
            check("bp_accept", rdy, 1);
        end
        tx_valid[0] = 1'b0;
        repeat (40) tick();
        check("bp_drain", acc0.size(), 0);

        // Divider of 4: byte 0x01.
        tx_valid[1] = 1'b1;
        tx_data[1]  = 8'h01;
        tick();
        tx_valid[1] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            logic exp_bit;
            @(posedge clk);
            @(negedge clk);
            exp_bit = (k < 4) ? 1'b0 : (k < 8) ? 1'b1 : (k < 36) ? 1'b0 : 1'b1;
            check($sformatf("div_line%0d", k), tx_out[1], exp_bit);
            check($sformatf("div_done%0d", k), done[1], k == 39);
        end

        // Reset during data bit 3 with a second byte held.
        repeat (3) tick();
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'($urandom);
        tick();
        tx_data[0] = 8'($urandom);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 2) tx_valid[0] = 1'b0;
        end
        check("mf_hold_full", tx_ready[0], 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mf_line", tx_out[0], 1);
        check("mf_ready", tx_ready[0], 1);
        check("mf_busy", busy[0], 0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("mf_quiet_busy", busy[0], 0);
            check("mf_quiet_line", tx_out[0], 1);
        end

        // Random traffic with occasional resets.
        for (int c = 0; c < 2000; c++) begin
            tick();
            rst = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < 2; i++) begin
                tx_valid[i] = ($urandom_range(0, 3) != 0);
                tx_data[i]  = 8'($urandom);
            end
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) tx_valid[i] = 1'b0;
        repeat (100) tick();
        check("drain0", acc0.size(), 0);
        check("drain1", acc1.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
